squash_game_ctrl: RTL and testbench
===================================

SQUASH_GAME_CTRL -- requirements
Module: squash_game_ctrl

Interface
REQ-001 SHALL have parameter SERVE_FRAMES, default 60, meaning frames held in SERVE before ball release (1..255).
REQ-002 SHALL have parameter MISS_FRAMES, default 90, meaning frames held in MISS before next serve (1..255).
REQ-003 SHALL have parameter TONE_FRAMES, default 4, meaning frames speaker_en stays high per hit (1..15).
REQ-004 SHALL have port clk  input  1  system clock, the only clock.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port frame_tick  input  1  one-cycle pulse per video frame, at vblank start.
REQ-007 SHALL have ports pause_n, new_game_n, up_key_n, down_key_n  input  1 each  raw active-low pushbuttons, asynchronous to clk.
REQ-008 SHALL have port ball_miss  input  1  one-cycle pulse: ball passed paddle.
REQ-009 SHALL have port ball_hit  input  1  one-cycle pulse: ball struck wall or paddle.
REQ-010 SHALL have port ball_step  output  1  one-cycle pulse permitting one ball move.
REQ-011 SHALL have ports paddle_up, paddle_down  output  1 each  one-cycle pulses permitting one paddle move.
REQ-012 SHALL have port ball_reset  output  1  one-cycle pulse recentring the ball.
REQ-013 SHALL have port speaker_en  output  1  level: tone gate.
REQ-014 SHALL have port lives  output  2  remaining lives.
REQ-015 SHALL have port state  output  3  current state encoding.

Function
REQ-016 Each button SHALL pass a 2-flop synchroniser, then be sampled only on frame_tick (debounce); press = debounced falling edge.
REQ-017 States/encodings SHALL be IDLE=0, SERVE=1, PLAY=2, PAUSE=3, MISS=4, OVER=5; 6 and 7 SHALL return to IDLE next cycle.
REQ-018 IDLE/OVER: new_game press -> SERVE, lives:=3, ball_reset pulsed in the transition cycle.
REQ-019 SERVE: frame counter loads SERVE_FRAMES on entry, decrements per frame_tick; reaching 0 -> PLAY.
REQ-020 PLAY: on each frame_tick assert ball_step same cycle; paddle_up if debounced up held, paddle_down if down held; both held -> neither.
REQ-021 PLAY: pause press -> PAUSE; PAUSE: pause press -> PLAY; no ball_step/paddle pulses in PAUSE.
REQ-022 PLAY: ball_miss -> MISS, counter loads MISS_FRAMES, lives decrements (saturating at 0).
REQ-023 MISS: counter reaching 0 -> OVER if lives==0, else SERVE with ball_reset pulse.
REQ-024 new_game press in any state except IDLE/OVER SHALL restart as REQ-018; priority new_game > ball_miss > pause.
REQ-025 ball_miss outside PLAY SHALL be ignored; ball_miss coincident with frame_tick in PLAY SHALL still emit that cycle's ball_step.
REQ-026 ball_hit in PLAY SHALL reload tone counter to TONE_FRAMES; speaker_en = (tone counter != 0); counter decrements per frame_tick; hit when nonzero restarts count.
REQ-027 Entering MISS SHALL force tone counter to TONE_FRAMES regardless of ball_hit.
REQ-028 All outputs SHALL be registered; pulses SHALL be exactly one clk wide.

Reset
REQ-029 reset_n low SHALL asynchronously force state=IDLE, lives=0, all counters 0, synchroniser/debounce flops to 1 (released), all pulse outputs and speaker_en 0.
REQ-030 Reset asserted mid-game SHALL abandon the game; after release the block SHALL wait in IDLE for new_game press.
REQ-031 A button held low through reset release SHALL NOT register a press until released and re-pressed.

Configuration
REQ-032 Macro SQUASH_CTRL_LIVES_EN defined: lives counting per REQ-018/022/023 and OVER reachable.
REQ-033 Macro undefined: no lives register, lives output tied to 2'b11, MISS always returns to SERVE, OVER unreachable.

Verification
REQ-034 Reset, new_game_n low over 2 frame ticks -> state 1, lives=3, one ball_reset; after 60 frame_ticks state=2.
REQ-035 PLAY, up_key_n held low 10 frames -> exactly 10 paddle_up pulses, 0 paddle_down; both keys low -> none.
REQ-036 PLAY, pause press -> state=3, 0 ball_step over 20 frames; second press -> state=2, ball_step resumes next frame_tick.
REQ-037 Three ball_miss events each followed by 90 frames -> lives 2,1,0, final state=5 (with SQUASH_CTRL_LIVES_EN); without macro state=1, lives=3.
REQ-038 ball_hit in PLAY -> speaker_en high for exactly 4 frame_ticks; reset_n pulsed low mid-PLAY -> state=0, all outputs 0 immediately.

Source files
------------

// File: rtl/squash_game_ctrl.sv
// Squash game controller: pushbutton synchronise/debounce, serve-play-miss sequencing and tone gate.
// Define SQUASH_CTRL_LIVES_EN to enable lives counting and the reachable OVER state.
module squash_game_ctrl #(
    parameter int SERVE_FRAMES = 60,
    parameter int MISS_FRAMES  = 90,
    parameter int TONE_FRAMES  = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_tick,
    input  logic       pause_n,
    input  logic       new_game_n,
    input  logic       up_key_n,
    input  logic       down_key_n,
    input  logic       ball_miss,
    input  logic       ball_hit,
    output logic       ball_step,
    output logic       paddle_up,
    output logic       paddle_down,
    output logic       ball_reset,
    output logic       speaker_en,
    output logic [1:0] lives,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        PAUSE = 3'd3,
        MISS  = 3'd4,
        OVER  = 3'd5
    } state_t;

    localparam int B_NEW   = 0;
    localparam int B_PAUSE = 1;
    localparam int B_UP    = 2;
    localparam int B_DOWN  = 3;

    state_t     st;
    logic [7:0] frame_cnt;
    logic [3:0] tone_cnt;
    logic [3:0] sync1, sync2, deb, armed, press;
    logic       up_move, down_move, start, take_miss, lives_zero;

    // Buttons are asynchronous to clk, hence two flops before any use. A button only
    // becomes armed once it has been sampled released, so a key held through reset
    // cannot produce a press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '1;
            sync2 <= '1;
            deb   <= '1;
            armed <= '0;
        end else begin
            sync1 <= {down_key_n, up_key_n, pause_n, new_game_n};
            sync2 <= sync1;
            if (frame_tick) begin
                deb   <= sync2;
                armed <= armed | sync2;
            end
        end
    end

    always_comb begin
        press     = {4{frame_tick}} & armed & deb & ~sync2;
        up_move   = frame_tick & ~sync2[B_UP] & sync2[B_DOWN];
        down_move = frame_tick & ~sync2[B_DOWN] & sync2[B_UP];
        start     = press[B_NEW] && (st inside {IDLE, SERVE, PLAY, PAUSE, MISS, OVER});
        take_miss = (st == PLAY) && ball_miss && !start;
    end

`ifdef SQUASH_CTRL_LIVES_EN
    logic [1:0] lives_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lives_q <= 2'd0;
        end else if (start) begin
            lives_q <= 2'd3;
        end else if (take_miss && lives_q != 2'd0) begin
            lives_q <= lives_q - 2'd1;
        end
    end

    assign lives      = lives_q;
    assign lives_zero = (lives_q == 2'd0);
`else
    assign lives      = 2'b11;
    assign lives_zero = 1'b0;
`endif

    assign state = st;

    // NOTE: sequential state uses non-blocking assignments only, so later lines in
    // this block (hit/miss tone reload) cleanly override the per-frame decrement.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st          <= IDLE;
            frame_cnt   <= 8'd0;
            tone_cnt    <= 4'd0;
            ball_step   <= 1'b0;
            paddle_up   <= 1'b0;
            paddle_down <= 1'b0;
            ball_reset  <= 1'b0;
            speaker_en  <= 1'b0;
        end else begin
            ball_step   <= 1'b0;
            paddle_up   <= 1'b0;
            paddle_down <= 1'b0;
            ball_reset  <= 1'b0;

            if (frame_tick && tone_cnt != 4'd0) begin
                tone_cnt   <= tone_cnt - 4'd1;
                speaker_en <= (tone_cnt != 4'd1);
            end

            if (start) begin
                st         <= SERVE;
                frame_cnt  <= 8'(SERVE_FRAMES);
                ball_reset <= 1'b1;
            end else begin
                case (st)
                    IDLE, OVER: ;
                    SERVE: begin
                        if (frame_tick) begin
                            if (frame_cnt <= 8'd1) begin
                                frame_cnt <= 8'd0;
                                st        <= PLAY;
                            end else begin
                                frame_cnt <= frame_cnt - 8'd1;
                            end
                        end
                    end
                    PLAY: begin
                        if (frame_tick) begin
                            ball_step   <= 1'b1;
                            paddle_up   <= up_move;
                            paddle_down <= down_move;
                        end
                        if (ball_hit || take_miss) begin
                            tone_cnt   <= 4'(TONE_FRAMES);
                            speaker_en <= 1'b1;
                        end
                        if (take_miss) begin
                            st        <= MISS;
                            frame_cnt <= 8'(MISS_FRAMES);
                        end else if (press[B_PAUSE]) begin
                            st <= PAUSE;
                        end
                    end
                    PAUSE: begin
                        if (press[B_PAUSE]) st <= PLAY;
                    end
                    MISS: begin
                        if (frame_tick) begin
                            if (frame_cnt <= 8'd1) begin
                                if (lives_zero) begin
                                    frame_cnt <= 8'd0;
                                    st        <= OVER;
                                end else begin
                                    frame_cnt  <= 8'(SERVE_FRAMES);
                                    st         <= SERVE;
                                    ball_reset <= 1'b1;
                                end
                            end else begin
                                frame_cnt <= frame_cnt - 8'd1;
                            end
                        end
                    end
                    default: st <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_squash_game_ctrl.sv
// Randomised bench for squash_game_ctrl: a frame-level game model predicts every output pulse
// into a scoreboard queue that an independent monitor drains; levels are also checked each frame.
module tb_squash_game_ctrl;

    localparam int SERVE_F   = 60;
    localparam int MISS_F    = 90;
    localparam int TONE_F    = 4;
    localparam int FRAME_LEN = 8;
    localparam int TICK_AT   = 4;

    localparam int S_IDLE  = 0;
    localparam int S_SERVE = 1;
    localparam int S_PLAY  = 2;
    localparam int S_PAUSE = 3;
    localparam int S_MISS  = 4;
    localparam int S_OVER  = 5;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       pause_n = 1'b1;
    logic       new_game_n = 1'b1;
    logic       up_key_n = 1'b1;
    logic       down_key_n = 1'b1;
    logic       ball_miss = 1'b0;
    logic       ball_hit = 1'b0;
    logic       ball_step, paddle_up, paddle_down, ball_reset, speaker_en;
    logic [1:0] lives;
    logic [2:0] state;

    squash_game_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .frame_tick (frame_tick),
        .pause_n    (pause_n),
        .new_game_n (new_game_n),
        .up_key_n   (up_key_n),
        .down_key_n (down_key_n),
        .ball_miss  (ball_miss),
        .ball_hit   (ball_hit),
        .ball_step  (ball_step),
        .paddle_up  (paddle_up),
        .paddle_down(paddle_down),
        .ball_reset (ball_reset),
        .speaker_en (speaker_en),
        .lives      (lives),
        .state      (state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         cyc;
        logic [3:0] pulses;   // {ball_reset, paddle_down, paddle_up, ball_step}
        int         st;
        int         lv;
        bit         spk;
    } exp_t;

    exp_t sb_q[$];

    // keys: 1 = released; bit 0 new_game, 1 pause, 2 up, 3 down
    logic [3:0] keys = 4'b1111;

    // Game model
    int       g_state, g_lives, g_timer, g_tone;
    bit [3:0] seen_high, last_keys;

    int up_seen = 0, down_seen = 0, step_seen = 0, rst_seen = 0, spk_ticks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic int lives_out();
`ifdef SQUASH_CTRL_LIVES_EN
        return g_lives;
`else
        return 3;
`endif
    endfunction

    function automatic void model_reset();
        g_state   = S_IDLE;
        g_lives   = 0;
        g_timer   = 0;
        g_tone    = 0;
        seen_high = 4'b0000;
        last_keys = 4'b1111;
    endfunction

    function automatic void model_cycle(bit tick, bit miss, bit hit);
        bit [3:0] press;
        bit s, u, d, r;
        exp_t e;
        press = 4'b0000;
        s = 0; u = 0; d = 0; r = 0;
        if (tick) begin
            press     = seen_high & last_keys & ~keys;
            seen_high = seen_high | keys;
            last_keys = keys;
            if (g_tone > 0) g_tone--;
        end
        if (press[0]) begin
            g_state = S_SERVE;
            g_timer = SERVE_F;
            g_lives = 3;
            r = 1;
        end else begin
            case (g_state)
                S_SERVE: if (tick) begin
                    g_timer--;
                    if (g_timer == 0) g_state = S_PLAY;
                end
                S_PLAY: begin
                    if (tick) begin
                        s = 1;
                        u = !keys[2] && keys[3];
                        d = !keys[3] && keys[2];
                    end
                    if (hit) g_tone = TONE_F;
                    if (miss) begin
                        g_state = S_MISS;
                        g_timer = MISS_F;
                        g_tone  = TONE_F;
                        if (g_lives > 0) g_lives--;
                    end else if (press[1]) begin
                        g_state = S_PAUSE;
                    end
                end
                S_PAUSE: if (press[1]) g_state = S_PLAY;
                S_MISS: if (tick) begin
                    g_timer--;
                    if (g_timer == 0) begin
                        if (lives_out() == 0) begin
                            g_state = S_OVER;
                        end else begin
                            g_state = S_SERVE;
                            g_timer = SERVE_F;
                            r = 1;
                        end
                    end
                end
                default: ;
            endcase
        end
        if (s || u || d || r) begin
            e.cyc    = cyc + 1;
            e.pulses = {r, d, u, s};
            e.st     = g_state;
            e.lv     = lives_out();
            e.spk    = (g_tone != 0);
            sb_q.push_back(e);
        end
    endfunction

    task automatic apply_keys();
        {down_key_n, up_key_n, pause_n, new_game_n} = keys;
    endtask

    task automatic drive_cycle(bit tick, bit miss, bit hit);
        @(negedge clk);
        if (tick) begin
            check("state_at_tick", state, g_state);
            check("lives_at_tick", lives, lives_out());
            check("speaker_at_tick", speaker_en, g_tone != 0);
            if (speaker_en) spk_ticks++;
        end
        frame_tick = tick;
        ball_miss  = miss;
        ball_hit   = hit;
        apply_keys();
        model_cycle(tick, miss, hit);
    endtask

    task automatic run_frames(int n, bit rand_keys, int hit_pm, int miss_pm,
                              bit force_hit, bit force_miss);
        for (int f = 0; f < n; f++) begin
            if (rand_keys) begin
                keys[0] = ($urandom_range(0, 39) != 0);
                keys[1] = ($urandom_range(0, 9) != 0);
                keys[2] = 1'($urandom_range(0, 1));
                keys[3] = 1'($urandom_range(0, 1));
            end
            for (int c = 0; c < FRAME_LEN; c++) begin
                bit h, m;
                h = (force_hit && f == 0 && c == 1) || ($urandom_range(0, 999) < hit_pm);
                m = (force_miss && f == 0 && c == 1) || ($urandom_range(0, 999) < miss_pm);
                drive_cycle(c == TICK_AT, m, h);
            end
        end
    endtask

    // One quiet cycle, then sample just after the clock edge.
    task automatic idle_sample();
        drive_cycle(1'b0, 1'b0, 1'b0);
        #6;
    endtask

    task automatic do_reset(bit hold_ng);
        @(negedge clk);
        #1;
        reset_n    = 1'b0;
        frame_tick = 1'b0;
        ball_miss  = 1'b0;
        ball_hit   = 1'b0;
        keys       = hold_ng ? 4'b1110 : 4'b1111;
        apply_keys();
        model_reset();
        sb_q.delete();
        #1;
        check("reset_state", state, S_IDLE);
        check("reset_lives", lives, lives_out());
        check("reset_pulses", {ball_reset, paddle_down, paddle_up, ball_step}, 0);
        check("reset_speaker", speaker_en, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
            total++;
            bad++;
            $display("FAIL missing_pulse: got none expected pulses=%b for cycle %0d", sb_q[0].pulses, sb_q[0].cyc);
            void'(sb_q.pop_front());
        end
        if (reset_n && (ball_step || paddle_up || paddle_down || ball_reset)) begin
            if (ball_step)   step_seen++;
            if (paddle_up)   up_seen++;
            if (paddle_down) down_seen++;
            if (ball_reset)  rst_seen++;
            if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
                e = sb_q.pop_front();
                check("pulses", {ball_reset, paddle_down, paddle_up, ball_step}, e.pulses);
                check("state_at_pulse", state, e.st);
                check("lives_at_pulse", lives, e.lv);
                check("speaker_at_pulse", speaker_en, e.spk);
            end else begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: got %b expected none at cycle %0d",
                         {ball_reset, paddle_down, paddle_up, ball_step}, cyc);
            end
        end
    end

    initial begin
        int u0, d0, s0, r0;
        model_reset();
        do_reset(1'b0);
        run_frames(3, 0, 0, 0, 0, 0);

        // New game, serve countdown, boundary one frame before release
        r0 = rst_seen;
        keys[0] = 1'b0;
        run_frames(2, 0, 0, 0, 0, 0);
        keys[0] = 1'b1;
        idle_sample();
        check("serve_state", state, S_SERVE);
        check("serve_lives", lives, 3);
        check("serve_ball_reset_count", rst_seen - r0, 1);
        run_frames(58, 0, 0, 0, 0, 0);
        idle_sample();
        check("serve_before_last_frame", state, S_SERVE);
        run_frames(1, 0, 0, 0, 0, 0);
        idle_sample();
        check("play_after_serve", state, S_PLAY);

        // Paddle: up held 10 frames, then both held
        u0 = up_seen; d0 = down_seen;
        keys[2] = 1'b0;
        run_frames(10, 0, 0, 0, 0, 0);
        keys[2] = 1'b1;
        run_frames(1, 0, 0, 0, 0, 0);
        check("up_pulse_count", up_seen - u0, 10);
        check("down_pulse_count", down_seen - d0, 0);
        u0 = up_seen; d0 = down_seen;
        keys[3:2] = 2'b00;
        run_frames(5, 0, 0, 0, 0, 0);
        keys[3:2] = 2'b11;
        run_frames(1, 0, 0, 0, 0, 0);
        check("both_up_count", up_seen - u0, 0);
        check("both_down_count", down_seen - d0, 0);

        // Pause and resume
        keys[1] = 1'b0;
        run_frames(1, 0, 0, 0, 0, 0);
        keys[1] = 1'b1;
        idle_sample();
        check("pause_state", state, S_PAUSE);
        s0 = step_seen;
        run_frames(20, 0, 0, 0, 0, 0);
        check("pause_no_steps", step_seen - s0, 0);
        keys[1] = 1'b0;
        run_frames(1, 0, 0, 0, 0, 0);
        keys[1] = 1'b1;
        idle_sample();
        check("resume_state", state, S_PLAY);
        s0 = step_seen;
        run_frames(1, 0, 0, 0, 0, 0);
        check("resume_step", step_seen - s0, 1);

        // Tone gate length
        spk_ticks = 0;
        run_frames(1, 0, 0, 0, 1, 0);
        run_frames(5, 0, 0, 0, 0, 0);
        check("tone_ticks", spk_ticks, TONE_F);

        // Randomised play without misses
        run_frames(60, 1, 30, 0, 0, 0);
        keys = 4'b1111;
        run_frames(2, 0, 0, 0, 0, 0);

        // Restart and lose three balls
        keys[0] = 1'b0;
        run_frames(1, 0, 0, 0, 0, 0);
        keys[0] = 1'b1;
        run_frames(60, 0, 0, 0, 0, 0);
        idle_sample();
        check("play_before_misses", state, S_PLAY);
        for (int m = 1; m <= 3; m++) begin
            run_frames(1, 0, 0, 0, 0, 1);
            run_frames(89, 0, 0, 0, 0, 0);
            idle_sample();
`ifdef SQUASH_CTRL_LIVES_EN
            check("miss_lives", lives, 3 - m);
            check("miss_next_state", state, (m < 3) ? S_SERVE : S_OVER);
`else
            check("miss_lives", lives, 3);
            check("miss_next_state", state, S_SERVE);
`endif
            if (m < 3) begin
                run_frames(60, 0, 0, 0, 0, 0);
                idle_sample();
                check("replay_state", state, S_PLAY);
            end
        end

        // Long randomised game with misses, pauses and restarts
        run_frames(400, 1, 25, 4, 0, 0);
        keys = 4'b1111;
        run_frames(1, 0, 0, 0, 0, 0);

        // Reset in the middle of play
        keys[0] = 1'b0;
        run_frames(1, 0, 0, 0, 0, 0);
        keys[0] = 1'b1;
        run_frames(60, 0, 0, 0, 0, 0);
        run_frames(3, 0, 20, 0, 0, 0);
        idle_sample();
        check("play_before_reset", state, S_PLAY);
        do_reset(1'b0);
        run_frames(3, 0, 0, 0, 0, 0);
        idle_sample();
        check("idle_after_reset", state, S_IDLE);

        // new_game held through reset release must not start a game
        do_reset(1'b1);
        run_frames(5, 0, 0, 0, 0, 0);
        idle_sample();
        check("held_through_reset", state, S_IDLE);
        keys[0] = 1'b1;
        run_frames(1, 0, 0, 0, 0, 0);
        keys[0] = 1'b0;
        run_frames(1, 0, 0, 0, 0, 0);
        keys[0] = 1'b1;
        idle_sample();
        check("repress_starts", state, S_SERVE);

        run_frames(2, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        check("scoreboard_drained", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
